ticket_pool: RTL and testbench

- Parametrised successor to the single-counter ticket allocator.
- Issues monotonically increasing wrap-around tickets to requesters.
- Tracks every outstanding ticket and accepts out-of-order retirement.
- Releases tickets strictly in issue order and stalls allocation when the configured number of tickets is in flight.
- Sits between request issuers (for example lookup/LPM stages) and their completion paths, to preserve response ordering.

---
 rtl/ticket_pool.sv | 172 +++++++++++++++++
 tb/tb_ticket_pool.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ticket_pool.sv
// ticket_pool -- ordered ticket allocator with out-of-order retirement.
//
// Hands out wrap-around ticket ids in increasing order. It remembers which outstanding
// tickets have completed, and releases them strictly in issue order, one per cycle.
// Allocation stalls while MAX_OUTSTANDING tickets are in flight.
//
// Optional feature: define TICKET_POOL_RETIRE_ERR_EN to add the sticky retireErr output.
// In that build every ignored (invalid) retire is also reported in simulation.
//
// Ports:
//   CLK, RST             clock (rising edge); asynchronous active-high reset
//   getTicket            id the next allocation will receive
//   getTicket__RDY       same as allocateTicket__RDY
//   allocateTicket__ENA  consume getTicket this cycle
//   allocateTicket__RDY  high while fewer than MAX_OUTSTANDING tickets are in flight
//   retireTicket__ENA    mark retireTicket_id as completed
//   retireTicket_id      id being retired
//   retireTicket__RDY    always 1
//   oldestTicket         head id (oldest unreleased; equals getTicket when empty)
//   outstanding          in-flight ticket count
//   empty                outstanding == 0
//   releaseTicket__ENA   registered one-cycle pulse per released head ticket
//   releaseTicket_id     id released with the pulse
//   retireErr            (TICKET_POOL_RETIRE_ERR_EN only) sticky invalid-retire flag

module ticket_pool #(
  parameter int unsigned TICKET_WIDTH    = 4,
  parameter int unsigned MAX_OUTSTANDING = 2 ** TICKET_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  output logic [TICKET_WIDTH-1:0] getTicket,
  output logic                    getTicket__RDY,
  input  logic                    allocateTicket__ENA,
  output logic                    allocateTicket__RDY,
  input  logic                    retireTicket__ENA,
  input  logic [TICKET_WIDTH-1:0] retireTicket_id,
  output logic                    retireTicket__RDY,
  output logic [TICKET_WIDTH-1:0] oldestTicket,
  output logic [TICKET_WIDTH:0]   outstanding,
  output logic                    empty,
  output logic                    releaseTicket__ENA,
  output logic [TICKET_WIDTH-1:0] releaseTicket_id
`ifdef TICKET_POOL_RETIRE_ERR_EN
  ,
  output logic                    retireErr
`endif
);

  localparam int unsigned NumIds = 2 ** TICKET_WIDTH;

  localparam logic [TICKET_WIDTH:0]   MaxCount = (TICKET_WIDTH + 1)'(MAX_OUTSTANDING);
  localparam logic [TICKET_WIDTH:0]   CountOne = (TICKET_WIDTH + 1)'(1);
  localparam logic [TICKET_WIDTH-1:0] IdOne    = TICKET_WIDTH'(1);

  // State.
  logic [TICKET_WIDTH-1:0] nextIdQ, nextIdD;
  logic [TICKET_WIDTH-1:0] headIdQ, headIdD;
  logic [TICKET_WIDTH:0]   countQ, countD;
  logic [NumIds-1:0]       doneQ, doneD;
  logic                    releaseEnaQ, releaseEnaD;
  logic [TICKET_WIDTH-1:0] releaseIdQ, releaseIdD;

  // Decoded per-cycle events.
  logic                    allocRdy;
  logic                    allocFire;
  logic [TICKET_WIDTH-1:0] retireOffset;
  logic                    retireInWindow;
  logic                    retireValid;
  logic                    releaseFire;

  always_comb begin
    // RDY looks at the registered count only, so a release this cycle does not
    // reopen allocation until the next cycle.
    allocRdy  = countQ < MaxCount;
    allocFire = allocateTicket__ENA && allocRdy;

    // Distance from head, modulo the id space. An id is outstanding exactly when
    // that distance is below the in-flight count; with count == 0 nothing qualifies.
    retireOffset   = retireTicket_id - headIdQ;
    retireInWindow = {1'b0, retireOffset} < countQ;
    retireValid    = retireTicket__ENA && retireInWindow && !doneQ[retireTicket_id];

    // The head may leave either because it was completed earlier or because it is
    // being retired right now.
    releaseFire = (countQ != '0) &&
                  (doneQ[headIdQ] || (retireValid && (retireTicket_id == headIdQ)));
  end

  always_comb begin
    doneD = doneQ;
    if (retireValid) begin
      doneD[retireTicket_id] = 1'b1;
    end
    // Clearing after the set handles a same-cycle retire-and-release of the head.
    if (releaseFire) begin
      doneD[headIdQ] = 1'b0;
    end
    // The slot being issued is never outstanding, so this cannot collide with the
    // retire above; it guarantees a fresh ticket starts not-done.
    if (allocFire) begin
      doneD[nextIdQ] = 1'b0;
    end

    nextIdD = allocFire ? nextIdQ + IdOne : nextIdQ;
    headIdD = releaseFire ? headIdQ + IdOne : headIdQ;

    unique case ({allocFire, releaseFire})
      2'b10:   countD = countQ + CountOne;
      2'b01:   countD = countQ - CountOne;
      default: countD = countQ;
    endcase

    releaseEnaD = releaseFire;
    releaseIdD  = releaseFire ? headIdQ : releaseIdQ;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nextIdQ     <= '0;
      headIdQ     <= '0;
      countQ      <= '0;
      doneQ       <= '0;
      releaseEnaQ <= 1'b0;
      releaseIdQ  <= '0;
    end else begin
      nextIdQ     <= nextIdD;
      headIdQ     <= headIdD;
      countQ      <= countD;
      doneQ       <= doneD;
      releaseEnaQ <= releaseEnaD;
      releaseIdQ  <= releaseIdD;
    end
  end

  assign getTicket          = nextIdQ;
  assign allocateTicket__RDY = allocRdy;
  assign getTicket__RDY     = allocRdy;
  assign retireTicket__RDY  = 1'b1;
  assign oldestTicket       = headIdQ;
  assign outstanding        = countQ;
  assign empty              = (countQ == '0);
  assign releaseTicket__ENA = releaseEnaQ;
  assign releaseTicket_id   = releaseIdQ;

`ifdef TICKET_POOL_RETIRE_ERR_EN
  logic retireErrQ;
  logic retireBad;

  assign retireBad = retireTicket__ENA && !retireValid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      retireErrQ <= 1'b0;
    end else if (retireBad) begin
      retireErrQ <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (!RST && retireBad) begin
      $display("ticket_pool: ignored retire id=%0d head=%0d count=%0d",
               retireTicket_id, headIdQ, countQ);
    end
  end
`endif

  assign retireErr = retireErrQ;
`endif

endmodule

// File: tb/tb_ticket_pool.sv
// Self-checking bench for ticket_pool (default parameters).
module tb_ticket_pool;

  localparam int TW    = 4;
  localparam int NIDS  = 16;
  localparam int MAXO  = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [TW-1:0] getTicket;
  logic          getTicket__RDY;
  logic          allocateTicket__ENA = 1'b0;
  logic          allocateTicket__RDY;
  logic          retireTicket__ENA = 1'b0;
  logic [TW-1:0] retireTicket_id = '0;
  logic          retireTicket__RDY;
  logic [TW-1:0] oldestTicket;
  logic [TW:0]   outstanding;
  logic          empty;
  logic          releaseTicket__ENA;
  logic [TW-1:0] releaseTicket_id;
`ifdef TICKET_POOL_RETIRE_ERR_EN
  logic          retireErr;
`endif

  int nTests = 0;
  int nFail  = 0;

  ticket_pool #(
    .TICKET_WIDTH   (TW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .getTicket          (getTicket),
    .getTicket__RDY     (getTicket__RDY),
    .allocateTicket__ENA(allocateTicket__ENA),
    .allocateTicket__RDY(allocateTicket__RDY),
    .retireTicket__ENA  (retireTicket__ENA),
    .retireTicket_id    (retireTicket_id),
    .retireTicket__RDY  (retireTicket__RDY),
    .oldestTicket       (oldestTicket),
    .outstanding        (outstanding),
    .empty              (empty),
    .releaseTicket__ENA (releaseTicket__ENA),
    .releaseTicket_id   (releaseTicket_id)
`ifdef TICKET_POOL_RETIRE_ERR_EN
    ,
    .retireErr          (retireErr)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs, wait for the edge, sample 1 time unit later.
  task automatic cycle(input bit a, input bit re, input int rid);
    allocateTicket__ENA = a;
    retireTicket__ENA   = re;
    retireTicket_id     = rid[TW-1:0];
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    allocateTicket__ENA = 1'b0;
    retireTicket__ENA   = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Reference model: issue-ordered queue of live ids plus a completed flag per id.
  int mq[$];
  bit mRet[NIDS];
  int mNext;

  task automatic modelReset();
    mq.delete();
    for (int k = 0; k < NIDS; k++) mRet[k] = 1'b0;
    mNext = 0;
  endtask

  task automatic modelStep(input bit a, input bit re, input int rid,
                           output bit relE, output int relI);
    bit canAlloc;
    bit live;
    canAlloc = mq.size() < MAXO;
    live = 1'b0;
    foreach (mq[k]) if (mq[k] == rid) live = 1'b1;
    if (re && live && !mRet[rid]) mRet[rid] = 1'b1;
    relE = 1'b0;
    relI = 0;
    if (mq.size() > 0 && mRet[mq[0]]) begin
      relE = 1'b1;
      relI = mq[0];
      mRet[mq[0]] = 1'b0;
      void'(mq.pop_front());
    end
    if (a && canAlloc) begin
      mq.push_back(mNext);
      mRet[mNext] = 1'b0;
      mNext = (mNext + 1) % NIDS;
    end
  endtask

  task automatic checkModel(input bit relE, input int relI);
    int sz;
    sz = mq.size();
    check("rnd_get", getTicket, mNext);
    check("rnd_out", outstanding, sz);
    check("rnd_old", oldestTicket, (sz > 0) ? mq[0] : mNext);
    check("rnd_empty", empty, (sz == 0) ? 1 : 0);
    check("rnd_rdy", allocateTicket__RDY, (sz < MAXO) ? 1 : 0);
    check("rnd_getrdy", getTicket__RDY, (sz < MAXO) ? 1 : 0);
    check("rnd_relena", releaseTicket__ENA, relE);
    if (relE) check("rnd_relid", releaseTicket_id, relI);
  endtask

  typedef struct {
    bit alloc;
    bit ret;
    int rid;
    int eGet;
    int eOut;
    int eOld;
    bit eRel;
    int eRelId;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit relE;
    int relI;
    int h;
    int rid;
    int bias;
    bit a;
    bit re;

    // Tests 1 and 2: allocate 0,1,2; retire 2,1 (held back); retire 0 drains all.
    vecs[0] = '{1, 0, 0, 1, 1, 0, 0, 0};
    vecs[1] = '{1, 0, 0, 2, 2, 0, 0, 0};
    vecs[2] = '{1, 0, 0, 3, 3, 0, 0, 0};
    vecs[3] = '{0, 1, 2, 3, 3, 0, 0, 0};
    vecs[4] = '{0, 1, 1, 3, 3, 0, 0, 0};
    vecs[5] = '{0, 1, 0, 3, 2, 1, 1, 0};
    vecs[6] = '{0, 0, 0, 3, 1, 2, 1, 1};
    vecs[7] = '{0, 0, 0, 3, 0, 3, 1, 2};
    vecs[8] = '{0, 0, 0, 3, 0, 3, 0, 0};

    doReset();
    check("rst_get", getTicket, 0);
    check("rst_old", oldestTicket, 0);
    check("rst_out", outstanding, 0);
    check("rst_empty", empty, 1);
    check("rst_rdy", allocateTicket__RDY, 1);
    check("rst_getrdy", getTicket__RDY, 1);
    check("rst_retrdy", retireTicket__RDY, 1);
    check("rst_relena", releaseTicket__ENA, 0);

    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].alloc, vecs[i].ret, vecs[i].rid);
      check($sformatf("vec%0d_get", i), getTicket, vecs[i].eGet);
      check($sformatf("vec%0d_out", i), outstanding, vecs[i].eOut);
      check($sformatf("vec%0d_old", i), oldestTicket, vecs[i].eOld);
      check($sformatf("vec%0d_empty", i), empty, (vecs[i].eOut == 0) ? 1 : 0);
      check($sformatf("vec%0d_relena", i), releaseTicket__ENA, vecs[i].eRel);
      if (vecs[i].eRel) check($sformatf("vec%0d_relid", i), releaseTicket_id, vecs[i].eRelId);
    end

    // Test 3: fill to 16, ignored 17th, release reopens RDY, next id wraps to 0.
    doReset();
    for (int i = 0; i < 16; i++) begin
      check("full_get_seq", getTicket, i);
      check("full_rdy_seq", allocateTicket__RDY, 1);
      cycle(1, 0, 0);
    end
    check("full_out", outstanding, 16);
    check("full_rdy", allocateTicket__RDY, 0);
    check("full_getrdy", getTicket__RDY, 0);
    check("full_get", getTicket, 0);
    cycle(1, 0, 0);
    check("full_ign_out", outstanding, 16);
    check("full_ign_get", getTicket, 0);
    check("full_ign_old", oldestTicket, 0);
    cycle(0, 1, 0);
    check("full_rel_ena", releaseTicket__ENA, 1);
    check("full_rel_id", releaseTicket_id, 0);
    check("full_rel_out", outstanding, 15);
    check("full_rel_rdy", allocateTicket__RDY, 1);
    check("full_rel_old", oldestTicket, 1);
    check("full_rel_get", getTicket, 0);
    cycle(1, 0, 0);
    check("full_re_out", outstanding, 16);
    check("full_re_get", getTicket, 1);
    check("full_re_old", oldestTicket, 1);
    check("full_re_rdy", allocateTicket__RDY, 0);
    check("full_re_relena", releaseTicket__ENA, 0);

    // Test 4: steady allocate + head retire; count constant, ids wrap.
    doReset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    h = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, h);
      check("steady_relena", releaseTicket__ENA, 1);
      check("steady_relid", releaseTicket_id, h);
      check("steady_out", outstanding, 5);
      check("steady_get", getTicket, (6 + i) % NIDS);
      h = (h + 1) % NIDS;
      check("steady_old", oldestTicket, h);
    end

`ifdef TICKET_POOL_RETIRE_ERR_EN
    // Test 5: invalid retires flag retireErr and leave state alone.
    doReset();
    check("err_rst", retireErr, 0);
    cycle(0, 1, 5);
    check("err_empty_flag", retireErr, 1);
    check("err_empty_out", outstanding, 0);
    check("err_empty_get", getTicket, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    check("err_dup_out", outstanding, 2);
    check("err_dup_old", oldestTicket, 0);
    check("err_dup_relena", releaseTicket__ENA, 0);
    check("err_sticky", retireErr, 1);
    cycle(0, 0, 0);
    check("err_sticky2", retireErr, 1);
    doReset();
    check("err_clr", retireErr, 0);
`endif

    // Test 6: asynchronous reset in the middle of a drain.
    doReset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    cycle(0, 1, 3);
    cycle(0, 1, 2);
    cycle(0, 1, 1);
    cycle(0, 1, 0);
    retireTicket__ENA = 1'b0;
    check("drain_start_relena", releaseTicket__ENA, 1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_get", getTicket, 0);
    check("arst_old", oldestTicket, 0);
    check("arst_out", outstanding, 0);
    check("arst_empty", empty, 1);
    check("arst_rdy", allocateTicket__RDY, 1);
    check("arst_relena", releaseTicket__ENA, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0);
      check("arst_norel", releaseTicket__ENA, 0);
      check("arst_out_hold", outstanding, 0);
    end

    // Randomised run against the reference model.
    doReset();
    modelReset();
    bias = 80;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) bias = (bias == 80) ? 30 : 80;
      a  = $urandom_range(0, 99) < bias;
      re = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) != 0 && mq.size() > 0) rid = mq[$urandom_range(0, mq.size() - 1)];
      else rid = $urandom_range(0, NIDS - 1);
      modelStep(a, re, rid, relE, relI);
      cycle(a, re, rid);
      checkModel(relE, relI);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
